pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 128, payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DS_LAG, default 2, cycles from pc advance to delay-slot flag update, legal range 1..8.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the payload.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port pc_adv  input  1  fetch PC advanced this cycle.
REQ-013 SHALL have port next_in_ds  input  1  next fetched instruction is a delay slot.
REQ-014 SHALL have port in_ds_o  output  1  registered delay-slot flag for decode.
REQ-015 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 SHALL hold two entries: main (drives out_data) and skid; states EMPTY, ONE, FULL; occupancy encodes 0/1/2.
REQ-017 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (state != FULL) from registers only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY) and out_data = main.
REQ-020 SHALL apply these transitions: EMPTY+accept -> ONE, main <= in_data.
REQ-021 SHALL apply ONE+accept+!emit -> FULL, skid <= in_data.
REQ-022 SHALL apply ONE+accept+emit -> ONE, main <= in_data.
REQ-023 SHALL apply ONE+!accept+emit -> EMPTY.
REQ-024 SHALL apply FULL+emit -> ONE, main <= skid; there is no accept in FULL.
REQ-025 SHALL hold all entries in any other case.
REQ-026 SHALL present a payload accepted in cycle N on out_data in cycle N+1 (latency 1) and SHALL preserve FIFO order.
REQ-027 SHALL give flush priority over simultaneous accept/emit: state <= EMPTY, main and skid <= 0, delay-slot state cleared.
REQ-028 SHALL, as delay-slot tracking, keep a DS_LAG-bit shift register hist <= {hist[DS_LAG-2:0], pc_adv} every cycle not in reset or flush; for DS_LAG = 1, hist <= pc_adv.
REQ-029 SHALL, when hist[DS_LAG-1] = 1, set in_ds_o <= saved | next_in_ds and clear saved.
REQ-030 SHALL otherwise, on accept, set saved <= saved | next_in_ds, and otherwise hold in_ds_o and saved.
REQ-031 SHALL not alter the transitions in REQ-020..025 when pc_adv and accept coincide.

Reset
REQ-032 SHALL, when rst is high at a clock edge, set state EMPTY, occupancy 0, out_valid 0, in_ready 1 (from next cycle), main/skid/out_data 0, hist 0, saved 0 and in_ds_o 0, regardless of other inputs.
REQ-033 SHALL treat rst asserted mid-transfer as a drop of all held payloads, with no emit in that cycle.

Structure
REQ-034 SHALL place the state enum (EMPTY/ONE/FULL) and the occupancy width constant in shared package pipe_pkg.
REQ-035 SHALL implement delay-slot tracking (hist, saved, in_ds_o) in sub-module pipe_ds_tracker, parametrised by DS_LAG.

Verification
REQ-036 SHALL test streaming: in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-037 SHALL test backpressure: out_ready=0, push 0xA then 0xB -> occupancy 2 and in_ready=0; release out_ready -> 0xA, then 0xB, with no loss or duplicate.
REQ-038 SHALL test flush in FULL with in_valid=1 the same cycle -> next cycle occupancy 0, out_valid 0, out_data 0, in_ds_o 0.
REQ-039 SHALL test the delay-slot flag: DS_LAG=2, next_in_ds=1 with accept at cycle 0, pc_adv=1 at cycle 1 -> in_ds_o=1 after cycle-3 edge, saved=0.
REQ-040 SHALL test reset mid-operation: rst in FULL with out_ready=1 -> no emit, occupancy 0, in_ready=1 the following cycle.
REQ-041 SHALL test WIDTH=1 and DS_LAG=1 builds -> REQ-036 and REQ-039 pass, with the flag updated one cycle after pc_adv.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid stage: occupancy state encoding and its width.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Encoding doubles as the occupancy count (0/1/2 held entries).
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake, payload and delay-slot signals between the skid stage and its neighbours.
interface pipe_skid_stage_if #(
  parameter int WIDTH = 128
);

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       pc_adv;
  logic                       next_in_ds;
  logic                       in_ds_o;
  logic [pipe_pkg::OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready, pc_adv, next_in_ds,
    input  in_ready, out_valid, out_data, in_ds_o, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready, pc_adv, next_in_ds,
    output in_ready, out_valid, out_data, in_ds_o, occupancy
  );

endinterface

// File: rtl/pipe_ds_tracker.sv
// Delay-slot flag tracker: the flag for decode is refreshed DS_LAG cycles after
// the fetch PC advances, folding in any delay-slot hints seen on accepted payloads.
module pipe_ds_tracker
  import pipe_pkg::*;
#(
  parameter int DS_LAG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic pc_adv,
  input  logic next_in_ds,
  input  logic accept,
  output logic in_ds_o
);

  logic [DS_LAG-1:0] hist_q, hist_d, hist_shift;
  logic              saved_q, saved_d;
  logic              in_ds_q, in_ds_d;

  generate
    if (DS_LAG == 1) begin : g_lag_one
      assign hist_shift = pc_adv;
    end else begin : g_lag_many
      assign hist_shift = {hist_q[DS_LAG-2:0], pc_adv};
    end
  endgenerate

  always_comb begin
    hist_d  = hist_q;
    saved_d = saved_q;
    in_ds_d = in_ds_q;
    if (flush) begin
      hist_d  = '0;
      saved_d = 1'b0;
      in_ds_d = 1'b0;
    end else begin
      hist_d = hist_shift;
      // The lagged PC advance wins over a same-cycle accept; its hint is folded in directly.
      if (hist_q[DS_LAG-1]) begin
        in_ds_d = saved_q | next_in_ds;
        saved_d = 1'b0;
      end else if (accept) begin
        saved_d = saved_q | next_in_ds;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      saved_q <= 1'b0;
      in_ds_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      saved_q <= saved_d;
      in_ds_q <= in_ds_d;
    end
  end

  assign in_ds_o = in_ds_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with registered ready and delay-slot tracking.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int DS_LAG = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipe_skid_stage_if.slave   bus
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             emit;

  // Ready depends only on the state register, never on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign emit      = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (accept && emit) begin
            main_d  = bus.in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_of(state_q);

  pipe_ds_tracker #(
    .DS_LAG (DS_LAG)
  ) u_ds (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .pc_adv     (bus.pc_adv),
    .next_in_ds (bus.next_in_ds),
    .accept     (accept),
    .in_ds_o    (bus.in_ds_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a WIDTH=128/DS_LAG=2 and a WIDTH=1/DS_LAG=1 instance
// driven in lockstep and compared against a FIFO-plus-timeline reference model.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_skid_stage_if #(.WIDTH(128)) bus_a ();
  pipe_skid_stage_if #(.WIDTH(1))   bus_b ();

  pipe_skid_stage #(.WIDTH(128), .DS_LAG(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipe_skid_stage #(.WIDTH(1),   .DS_LAG(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: held payloads as a 2-deep FIFO, plus a per-cycle pc_adv timeline.
  int           m_cnt = 0;
  logic [127:0] m_dat [2];
  bit           ds_flag [2];
  bit           ds_saved [2];
  bit           pch [0:4095];
  int           last_clear = -1;
  int           cyc = 0;
  int           lag [2] = '{2, 1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_occ",   128'(bus_a.occupancy), 128'(m_cnt));
    chk("a_rdy",   128'(bus_a.in_ready),  128'(m_cnt < 2));
    chk("a_vld",   128'(bus_a.out_valid), 128'(m_cnt > 0));
    chk("a_data",  bus_a.out_data,        m_dat[0]);
    chk("a_ds",    128'(bus_a.in_ds_o),   128'(ds_flag[0]));
    chk("b_occ",   128'(bus_b.occupancy), 128'(m_cnt));
    chk("b_rdy",   128'(bus_b.in_ready),  128'(m_cnt < 2));
    chk("b_vld",   128'(bus_b.out_valid), 128'(m_cnt > 0));
    chk("b_data",  128'(bus_b.out_data),  128'(m_dat[0][0]));
    chk("b_ds",    128'(bus_b.in_ds_o),   128'(ds_flag[1]));
  endtask

  // Drive one cycle, advance the model across the edge, then check at the next negedge.
  task automatic cycle(input bit r, input bit f, input bit v, input logic [127:0] d,
                       input bit ordy, input bit pca, input bit nds);
    bit acc, em, clr;
    int src;
    rst = r;
    bus_a.flush = f;      bus_b.flush = f;
    bus_a.in_valid = v;   bus_b.in_valid = v;
    bus_a.in_data = d;    bus_b.in_data = d[0];
    bus_a.out_ready = ordy; bus_b.out_ready = ordy;
    bus_a.pc_adv = pca;   bus_b.pc_adv = pca;
    bus_a.next_in_ds = nds; bus_b.next_in_ds = nds;

    acc = v && (m_cnt < 2);
    em  = (m_cnt > 0) && ordy;
    clr = r || f;
    for (int k = 0; k < 2; k++) begin
      src = cyc - lag[k];
      if (clr) begin
        ds_flag[k]  = 1'b0;
        ds_saved[k] = 1'b0;
      end else if (src > last_clear && src >= 0 && pch[src]) begin
        ds_flag[k]  = ds_saved[k] | nds;
        ds_saved[k] = 1'b0;
      end else if (acc) begin
        ds_saved[k] = ds_saved[k] | nds;
      end
    end
    if (clr) begin
      m_cnt = 0;
      m_dat[0] = '0;
      m_dat[1] = '0;
    end else begin
      if (em) begin
        if (m_cnt == 2) m_dat[0] = m_dat[1];
        m_cnt--;
      end
      if (acc) begin
        m_dat[m_cnt] = d;
        m_cnt++;
      end
    end
    pch[cyc] = pca;
    if (clr) last_clear = cyc;
    cyc++;

    @(negedge clk);
    check_all();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    cycle(1, 0, 0, '0, 0, 0, 0);
    cycle(1, 0, 1, 128'h5, 1, 1, 1);
    chk("reset_occ", 128'(bus_a.occupancy), 128'd0);
    chk("reset_rdy", 128'(bus_a.in_ready),  128'd1);

    // Streaming: one payload per cycle, occupancy stays at one
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 1, 128'(i), 1, 0, 0);
      chk("stream_data", bus_a.out_data, 128'(i));
      chk("stream_occ",  128'(bus_a.occupancy), 128'd1);
      chk("stream_rdy",  128'(bus_a.in_ready), 128'd1);
    end
    cycle(0, 0, 0, '0, 1, 0, 0);

    // Backpressure: fill to FULL, offer a third payload, then drain in order
    cycle(0, 0, 1, 128'hA, 0, 0, 0);
    cycle(0, 0, 1, 128'hB, 0, 0, 0);
    chk("bp_occ",  128'(bus_a.occupancy), 128'd2);
    chk("bp_rdy",  128'(bus_a.in_ready),  128'd0);
    cycle(0, 0, 1, 128'hC, 0, 0, 0);
    chk("bp_hold", bus_a.out_data, 128'hA);
    cycle(0, 0, 0, '0, 1, 0, 0);
    chk("bp_second", bus_a.out_data, 128'hB);
    chk("bp_occ1",   128'(bus_a.occupancy), 128'd1);
    cycle(0, 0, 0, '0, 1, 0, 0);
    chk("bp_empty",  128'(bus_a.occupancy), 128'd0);

    // Flush while FULL with a simultaneous offer
    cycle(0, 0, 1, 128'h11, 0, 0, 1);
    cycle(0, 0, 1, 128'h22, 0, 0, 1);
    cycle(0, 1, 1, 128'h33, 1, 0, 1);
    chk("flush_occ",  128'(bus_a.occupancy), 128'd0);
    chk("flush_vld",  128'(bus_a.out_valid), 128'd0);
    chk("flush_data", bus_a.out_data, 128'd0);
    chk("flush_ds",   128'(bus_a.in_ds_o), 128'd0);

    // Delay-slot flag: hint on accept at cycle 0, pc advance at cycle 1
    cycle(0, 0, 1, 128'h44, 1, 0, 1);
    cycle(0, 0, 0, '0, 1, 1, 0);
    cycle(0, 0, 0, '0, 1, 0, 0);
    chk("ds_b_lag1", 128'(bus_b.in_ds_o), 128'd1);
    chk("ds_a_early", 128'(bus_a.in_ds_o), 128'd0);
    cycle(0, 0, 0, '0, 1, 0, 0);
    chk("ds_a_lag2", 128'(bus_a.in_ds_o), 128'd1);
    chk("ds_saved",  128'(dut_a.u_ds.saved_q), 128'd0);

    // Reset while FULL with out_ready high: payloads dropped
    cycle(0, 0, 1, 128'h66, 0, 0, 0);
    cycle(0, 0, 1, 128'h77, 0, 0, 0);
    cycle(1, 0, 1, 128'h88, 1, 0, 0);
    chk("rst_occ",  128'(bus_a.occupancy), 128'd0);
    chk("rst_rdy",  128'(bus_a.in_ready),  128'd1);
    chk("rst_data", bus_a.out_data, 128'd0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom()), rnd128(), 1'($urandom()),
            ($urandom_range(0, 3) == 0), 1'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
